serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Processes one bit per clock through a single combinational full-subtractor cell and a registered borrow flop.
- Arithmetic companion to the adder datapath; the subtract direction of the same ripple arithmetic, traded for area.
- Start/busy/done handshake to a controlling FSM.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the sizing rule for the bit-step counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Counter width for a block of the given operand width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the subtract-direction twin of full_adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per
// clock through a single full_subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   r_sr;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               a_msb;
  logic               b_msb;
  logic               d_bit;
  logic               b_bit;
  logic               load;
  logic [WIDTH-1:0]   r_next;

  full_subtractor u_fs (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .b_in  (borrow),
    .diff  (d_bit),
    .b_out (b_bit)
  );

  assign load   = start && ((state == IDLE) || (state == DONE));
  assign r_next = {d_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (load) begin
      // Reload from IDLE or straight out of DONE for back-to-back operation.
      state  <= SHIFT;
      a_sr   <= a;
      b_sr   <= b;
      r_sr   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= b_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            // Results are taken from the final step directly so they are
            // valid in the same cycle done is asserted.
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= r_next;
            borrow_out <= b_bit;
            overflow   <= (a_msb != b_msb) && (d_bit != a_msb);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, bo8, ov8;
  logic [7:0]  diff8;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16, bo16, ov16;
  logic [15:0] diff16;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt8 = 0;
  logic done8_q = 1'b0;
  logic done16_q = 1'b0;

  exp_t sb8[$];
  exp_t sb16[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8),
    .overflow   (ov8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start16),
    .a          (a16),
    .b          (b16),
    .busy       (busy16),
    .done       (done16),
    .diff       (diff16),
    .borrow_out (bo16),
    .overflow   (ov16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] mask;
    logic [15:0] d;
    mask     = (17'd1 << w) - 17'd1;
    d        = (a - b) & mask[15:0];
    e.diff   = d;
    e.borrow = (a < b);
    e.ovf    = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    check("busy_done_excl8", 32'(busy8 & done8), 32'd0);
    check("done_consec8", 32'(done8 & done8_q), 32'd0);
    check("busy_done_excl16", 32'(busy16 & done16), 32'd0);
    check("done_consec16", 32'(done16 & done16_q), 32'd0);
    done8_q  <= done8;
    done16_q <= done16;
    if (done8) begin
      done_cnt8++;
      if (sb8.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        check("diff8", 32'(diff8), 32'(e.diff));
        check("borrow8", 32'(bo8), 32'(e.borrow));
        check("ovf8", 32'(ov8), 32'(e.ovf));
      end
    end
    if (done16) begin
      if (sb16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = sb16.pop_front();
        check("diff16", 32'(diff16), 32'(e.diff));
        check("borrow16", 32'(bo16), 32'(e.borrow));
        check("ovf16", 32'(ov16), 32'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an 8-bit op from the current cycle; returns #1 into the done cycle.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    sb8.push_back(model(8, {8'd0, a}, {8'd0, b}));
    step();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("busy8_shift", 32'(busy8), 32'd1);
      check("done8_shift", 32'(done8), 32'd0);
      step();
    end
    check("done8_latency", 32'(done8), 32'd1);
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1;
    a16 = a;
    b16 = b;
    sb16.push_back(model(16, a, b));
    step();
    start16 = 1'b0;
    repeat (16) step();
    check("done16_latency", 32'(done16), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(bo8), 32'd0);
    check("rst_ovf", 32'(ov8), 32'd0);
    rst_n = 1'b1;
    step();

    do_op8(8'h5A, 8'h21);
    step();
    do_op8(8'h10, 8'h20);
    step();
    do_op8(8'h00, 8'h01);
    step();
    do_op8(8'h80, 8'h01);
    step();
    do_op8(8'h7F, 8'hFF);
    step();
    check("idle_after_done", 32'(busy8 | done8), 32'd0);

    // start held high through SHIFT while operands wander
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h21;
    sb8.push_back(model(8, 16'h005A, 16'h0021));
    step();
    for (int k = 1; k <= 8; k++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      step();
    end
    start8 = 1'b0;
    check("hold_done", 32'(done8), 32'd1);
    step();
    check("hold_no_reload", 32'(busy8), 32'd0);
    step();

    // back-to-back reload from the DONE cycle
    do_op8(8'h5A, 8'h21);
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h01;
    sb8.push_back(model(8, 16'h0003, 16'h0001));
    step();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("b2b_busy", 32'(busy8), 32'd1);
      check("b2b_diff_hold", 32'(diff8), 32'h39);
      step();
    end
    check("b2b_done", 32'(done8), 32'd1);
    step();

    // reset in cycle 4 of SHIFT
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5E;
    sb8.push_back(model(8, 16'h00C3, 16'h005E));
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    sb8.delete();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_diff", 32'(diff8), 32'd0);
    dc = done_cnt8;
    repeat (20) step();
    check("mid_rst_no_done", 32'(done_cnt8 - dc), 32'd0);
    do_op8(8'hC3, 8'h5E);
    step();

    for (int i = 0; i < 1000; i++) do_op8(8'($urandom), 8'($urandom));
    step();
    do_op16(16'h8000, 16'h0001);
    step();
    for (int i = 0; i < 1000; i++) do_op16(16'($urandom), 16'($urandom));
    step();
    step();
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb16_drained", 32'(sb16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
